sw_btn_input_periph: RTL and testbench



---
 rtl/sw_btn_input_periph_pkg.sv | 15 +
 rtl/sw_btn_input_periph_debouncer.sv | 53 +++++
 rtl/sw_btn_input_periph.sv | 154 +++++++++++++++
 tb/tb_sw_btn_input_periph.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sw_btn_input_periph_pkg.sv
// Shared register map and bus FSM encoding for the switch/button input peripheral.
package sw_btn_pkg;

  localparam logic [4:0] REG_DATA = 5'h00;
  localparam logic [4:0] REG_PEND = 5'h04;
  localparam logic [4:0] REG_MASK = 5'h08;
  localparam logic [4:0] REG_RISE = 5'h0C;
  localparam logic [4:0] REG_FALL = 5'h10;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    ACK  = 1'b1
  } bus_state_t;

endpackage

// File: rtl/sw_btn_input_periph_debouncer.sv
// One-bit 2-FF synchroniser followed by a persistence-count debouncer.
module input_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic pin_i,
  output logic deb_o
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          deb_q;
  logic          deb_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Count while the synchronised level disagrees; accept it once it has held long enough.
  always_comb begin
    deb_d = deb_q;
    cnt_d = {CW{1'b0}};
    if (sync2_q != deb_q) begin
      if (cnt_q == CNT_MAX) begin
        deb_d = sync2_q;
        cnt_d = {CW{1'b0}};
      end else begin
        cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
      end
    end else begin
      cnt_d = {CW{1'b0}};
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      deb_q   <= 1'b0;
      cnt_q   <= {CW{1'b0}};
    end else begin
      sync1_q <= pin_i;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
    end
  end

  assign deb_o = deb_q;

endmodule

// File: rtl/sw_btn_input_periph.sv
// Memory-mapped switch/button input block: debounce, edge events, W1C pending
// register, maskable level interrupt and a single-cycle-latency bus slave.
module sw_btn_input_periph
  import sw_btn_pkg::*;
#(
  parameter int N_SW            = 8,
  parameter int N_BTN           = 2,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int ADDR_W          = 5
) (
  input  logic              clk_sys,
  input  logic              rst,
  input  logic [N_SW-1:0]   sw,
  input  logic [N_BTN-1:0]  btn,
  input  logic              bus_stb,
  input  logic              bus_we,
  input  logic [ADDR_W-1:0] bus_adr,
  input  logic [31:0]       bus_dat_i,
  output logic [31:0]       bus_dat_o,
  output logic              bus_ack,
  output logic              irq
);

  localparam int N_IN = N_SW + N_BTN;
  localparam logic [ADDR_W-1:0] OFF_DATA = ADDR_W'(REG_DATA);
  localparam logic [ADDR_W-1:0] OFF_PEND = ADDR_W'(REG_PEND);
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(REG_MASK);
  localparam logic [ADDR_W-1:0] OFF_RISE = ADDR_W'(REG_RISE);
  localparam logic [ADDR_W-1:0] OFF_FALL = ADDR_W'(REG_FALL);

  logic [N_IN-1:0]   in_vec;
  logic [N_IN-1:0]   deb_s;
  logic [N_IN-1:0]   deb_q;
  logic [N_IN-1:0]   ev_s;
  logic [N_IN-1:0]   clr_s;
  logic [N_IN-1:0]   wdata_s;
  logic [ADDR_W-1:0] off_s;
  logic [31:0]       rdata_s;
  logic              go_s;
  logic              unused_ok;

  bus_state_t        state_q, state_d;
  logic              ack_q, ack_d;
  logic              armed_q, armed_d;
  logic [31:0]       dat_q, dat_d;
  logic [N_IN-1:0]   pend_q, pend_d;
  logic [N_IN-1:0]   mask_q, mask_d;
  logic [N_IN-1:0]   rise_q, rise_d;
  logic [N_IN-1:0]   fall_q, fall_d;
  logic              irq_q, irq_d;

  assign in_vec = {btn, sw};

  for (genvar g = 0; g < N_IN; g++) begin : g_deb
    input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .clk_i (clk_sys),
      .rst_ni(rst),
      .pin_i (in_vec[g]),
      .deb_o (deb_s[g])
    );
  end

  assign ev_s    = (deb_s & ~deb_q & rise_q) | (~deb_s & deb_q & fall_q);
  assign off_s   = {bus_adr[ADDR_W-1:2], 2'b00};
  assign wdata_s = bus_dat_i[N_IN-1:0];
  // A held strobe must drop before another transfer may start.
  assign go_s    = (state_q == IDLE) && bus_stb && armed_q;
  assign clr_s   = (go_s && bus_we && (off_s == OFF_PEND)) ? wdata_s : {N_IN{1'b0}};
  assign unused_ok = ^{bus_adr[1:0], bus_dat_i[31:N_IN]};

  always_comb begin
    case (off_s)
      OFF_DATA: rdata_s = 32'(deb_s);
      OFF_PEND: rdata_s = 32'(pend_q);
      OFF_MASK: rdata_s = 32'(mask_q);
      OFF_RISE: rdata_s = 32'(rise_q);
      OFF_FALL: rdata_s = 32'(fall_q);
      default:  rdata_s = 32'h0000_0000;
    endcase
  end

  always_comb begin
    state_d = state_q;
    ack_d   = 1'b0;
    dat_d   = 32'h0000_0000;
    mask_d  = mask_q;
    rise_d  = rise_q;
    fall_d  = fall_q;
    irq_d   = |(pend_q & mask_q);
    // New events win over a same-cycle clear.
    pend_d  = (pend_q & ~clr_s) | ev_s;
    case (state_q)
      IDLE: begin
        if (go_s) begin
          state_d = ACK;
          ack_d   = 1'b1;
          dat_d   = rdata_s;
        end else begin
          state_d = IDLE;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (!bus_stb) begin
      armed_d = 1'b1;
    end else if (go_s) begin
      armed_d = 1'b0;
    end else begin
      armed_d = armed_q;
    end
    if (go_s && bus_we) begin
      case (off_s)
        OFF_MASK: mask_d = wdata_s;
        OFF_RISE: rise_d = wdata_s;
        OFF_FALL: fall_d = wdata_s;
        default:  mask_d = mask_q;
      endcase
    end else begin
      mask_d = mask_q;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!rst) begin
      state_q <= IDLE;
      ack_q   <= 1'b0;
      armed_q <= 1'b1;
      dat_q   <= 32'h0000_0000;
      deb_q   <= {N_IN{1'b0}};
      pend_q  <= {N_IN{1'b0}};
      mask_q  <= {N_IN{1'b0}};
      rise_q  <= {N_IN{1'b0}};
      fall_q  <= {N_IN{1'b0}};
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      armed_q <= armed_d;
      dat_q   <= dat_d;
      deb_q   <= deb_s;
      pend_q  <= pend_d;
      mask_q  <= mask_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      irq_q   <= irq_d;
    end
  end

  assign bus_dat_o = dat_q;
  assign bus_ack   = ack_q;
  assign irq       = irq_q;

endmodule

// File: tb/tb_sw_btn_input_periph.sv
// Directed plus randomized bench for sw_btn_input_periph, checked every cycle
// against a behavioural model of the peripheral.
module tb_sw_btn_input_periph;

  localparam int NI = 10;
  localparam int DC = 4;

  logic        clk_sys = 1'b1;
  logic        rst = 1'b0;
  logic [7:0]  sw = 8'hFF;
  logic [1:0]  btn = 2'b00;
  logic        bus_stb = 1'b0;
  logic        bus_we = 1'b0;
  logic [4:0]  bus_adr = 5'h00;
  logic [31:0] bus_dat_i = 32'h0;
  logic [31:0] bus_dat_o;
  logic        bus_ack;
  logic        irq;

  int n_checks = 0;
  int n_pass = 0;
  logic check_en = 1'b0;

  sw_btn_input_periph #(
    .N_SW(8), .N_BTN(2), .DEBOUNCE_CYCLES(DC), .ADDR_W(5)
  ) dut (
    .clk_sys(clk_sys), .rst(rst), .sw(sw), .btn(btn),
    .bus_stb(bus_stb), .bus_we(bus_we), .bus_adr(bus_adr),
    .bus_dat_i(bus_dat_i), .bus_dat_o(bus_dat_o), .bus_ack(bus_ack), .irq(irq)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  logic [NI-1:0] m_s1 = '0, m_s2 = '0, m_last = '0, m_deb = '0, m_debp = '0;
  logic [NI-1:0] m_pend = '0, m_mask = '0, m_rise = '0, m_fall = '0;
  logic          m_ack = 1'b0, m_armed = 1'b1, m_irq = 1'b0;
  logic [31:0]   m_dat = 32'h0;
  int            m_run [NI];

  // Advance the model by one rising edge using the inputs currently applied.
  task automatic model_step();
    logic [NI-1:0] pin, ev, clr, n_deb;
    logic [31:0]   rd;
    logic [4:0]    off;
    logic          go;
    pin = {btn, sw};
    if (!rst) begin
      m_s1 = '0; m_s2 = '0; m_last = '0; m_deb = '0; m_debp = '0;
      m_pend = '0; m_mask = '0; m_rise = '0; m_fall = '0;
      m_ack = 1'b0; m_armed = 1'b1; m_irq = 1'b0; m_dat = 32'h0;
      for (int i = 0; i < NI; i++) m_run[i] = 0;
    end else begin
      ev  = (m_deb & ~m_debp & m_rise) | (~m_deb & m_debp & m_fall);
      go  = bus_stb && m_armed && !m_ack;
      off = {bus_adr[4:2], 2'b00};
      case (off)
        5'h00:   rd = 32'(m_deb);
        5'h04:   rd = 32'(m_pend);
        5'h08:   rd = 32'(m_mask);
        5'h0C:   rd = 32'(m_rise);
        5'h10:   rd = 32'(m_fall);
        default: rd = 32'h0;
      endcase
      clr = (go && bus_we && off == 5'h04) ? bus_dat_i[NI-1:0] : '0;
      n_deb = m_deb;
      // A synchronised level is accepted once it has been seen for DC edges in a row.
      for (int i = 0; i < NI; i++) begin
        if (m_s2[i] == m_last[i]) m_run[i] = m_run[i] + 1;
        else m_run[i] = 1;
        m_last[i] = m_s2[i];
        if (m_s2[i] != m_deb[i] && m_run[i] >= DC) n_deb[i] = m_s2[i];
      end
      m_irq  = |(m_pend & m_mask);
      m_pend = (m_pend & ~clr) | ev;
      if (go && bus_we && off == 5'h08) m_mask = bus_dat_i[NI-1:0];
      if (go && bus_we && off == 5'h0C) m_rise = bus_dat_i[NI-1:0];
      if (go && bus_we && off == 5'h10) m_fall = bus_dat_i[NI-1:0];
      m_debp = m_deb;
      m_deb  = n_deb;
      m_s2   = m_s1;
      m_s1   = pin;
      if (go) m_armed = 1'b0;
      else if (!bus_stb) m_armed = 1'b1;
      m_ack = go;
      m_dat = go ? rd : 32'h0;
    end
  endtask

  initial begin
    forever begin
      @(negedge clk_sys);
      if (check_en) begin
        chk("cyc_ack", 32'(bus_ack), 32'(m_ack));
        chk("cyc_dat", bus_dat_o, m_dat);
        chk("cyc_irq", 32'(irq), 32'(m_irq));
      end
      model_step();
    end
  end

  // ---------------- bus helpers ----------------
  task automatic idle(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic bus_xfer(input logic we, input logic [4:0] adr, input logic [31:0] wd,
                          output logic [31:0] rd);
    bus_stb = 1'b1; bus_we = we; bus_adr = adr; bus_dat_i = wd;
    @(posedge clk_sys); #1;
    bus_stb = 1'b0; bus_we = 1'b0;
    chk("xfer_ack", 32'(bus_ack), 32'd1);
    rd = bus_dat_o;
    @(posedge clk_sys); #1;
  endtask

  task automatic rd_chk(input string nm, input logic [4:0] adr, input logic [31:0] exp);
    logic [31:0] d;
    bus_xfer(1'b0, adr, 32'h0, d);
    chk(nm, d, exp);
  endtask

  task automatic wr(input logic [4:0] adr, input logic [31:0] wd);
    logic [31:0] d;
    bus_xfer(1'b1, adr, wd, d);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int acks;
    int b;
    @(posedge clk_sys); #1;
    check_en = 1'b1;
    idle(2);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_ack", 32'(bus_ack), 32'd0);
    rst = 1'b1;
    rd_chk("rst_data", 5'h00, 32'h0);
    rd_chk("rst_pend", 5'h04, 32'h0);
    rd_chk("rst_mask", 5'h08, 32'h0);
    rd_chk("rst_rise", 5'h0C, 32'h0);
    rd_chk("rst_fall", 5'h10, 32'h0);
    idle(10);
    rd_chk("data_ff", 5'h00, 32'h0FF);
    rd_chk("pend_no_rise", 5'h04, 32'h0);

    // debounce latency and glitch rejection
    sw = 8'hAA;
    idle(5);
    rd_chk("data_before", 5'h00, 32'h0FF);
    rd_chk("data_after", 5'h00, 32'h0AA);
    sw = 8'hAB;
    idle(3);
    sw = 8'hAA;
    idle(10);
    rd_chk("glitch_data", 5'h00, 32'h0AA);

    // edge events and interrupt
    wr(5'h0C, 32'h3FF);
    wr(5'h08, 32'h300);
    sw = 8'hAE;
    idle(10);
    rd_chk("pend_sw", 5'h04, 32'h004);
    chk("irq_masked", 32'(irq), 32'd0);
    btn = 2'b10;
    idle(20);
    btn = 2'b00;
    idle(10);
    rd_chk("pend_btn", 5'h04, 32'h204);
    chk("irq_btn", 32'(irq), 32'd1);

    // W1C
    wr(5'h04, 32'h004);
    rd_chk("w1c_bit2", 5'h04, 32'h200);
    wr(5'h04, 32'h000);
    rd_chk("w1c_zero", 5'h04, 32'h200);
    wr(5'h04, 32'h200);
    chk("irq_clear", 32'(irq), 32'd0);
    rd_chk("w1c_all", 5'h04, 32'h000);

    // set wins over same-cycle clear
    sw = 8'hAF;
    idle(10);
    rd_chk("pend_b0", 5'h04, 32'h001);
    wr(5'h10, 32'h001);
    sw = 8'hAE;
    idle(6);
    wr(5'h04, 32'h001);
    rd_chk("set_wins", 5'h04, 32'h001);
    wr(5'h04, 32'h001);
    rd_chk("b0_clear", 5'h04, 32'h000);

    // held strobe gives one ack
    wr(5'h08, 32'h3FF);
    acks = 0;
    bus_stb = 1'b1; bus_we = 1'b0; bus_adr = 5'h00;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk_sys); #1;
      if (bus_ack) acks++;
      if (i == 3) bus_stb = 1'b0;
    end
    chk("held_stb_acks", 32'(acks), 32'd1);
    rd_chk("off_14", 5'h14, 32'h0);
    rd_chk("off_1f", 5'h1F, 32'h0);

    // reset drops an in-flight transfer
    bus_stb = 1'b1; bus_we = 1'b1; bus_adr = 5'h08; bus_dat_i = 32'h0;
    rst = 1'b0;
    @(posedge clk_sys); #1;
    chk("rst_xfer_ack", 32'(bus_ack), 32'd0);
    bus_stb = 1'b0; bus_we = 1'b0;
    @(posedge clk_sys); #1;
    chk("rst_xfer_ack2", 32'(bus_ack), 32'd0);
    rst = 1'b1;
    rd_chk("rst2_pend", 5'h04, 32'h0);
    rd_chk("rst2_mask", 5'h08, 32'h0);
    rd_chk("rst2_rise", 5'h0C, 32'h0);
    rd_chk("rst2_fall", 5'h10, 32'h0);
    chk("rst2_irq", 32'(irq), 32'd0);

    // randomized traffic, checked by the per-cycle compare
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 5) == 0) begin
        b = int'($urandom_range(0, 9));
        if (b < 8) sw[b] = ~sw[b];
        else btn[b-8] = ~btn[b-8];
      end
      bus_stb   = ($urandom_range(0, 3) == 0);
      bus_we    = 1'($urandom_range(0, 1));
      bus_adr   = 5'($urandom_range(0, 31));
      bus_dat_i = $urandom();
      rst       = ($urandom_range(0, 400) != 0);
      @(posedge clk_sys); #1;
    end
    bus_stb = 1'b0;
    rst = 1'b1;
    idle(5);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
